// File: rtl/adder_behav_pkg.sv
// adder_behav_pkg -- shared constants and types for the adder_behav slice.
//   SLICE_W   : width of one carry-lookahead slice (fixed at 4)
//   WIDTH_DEF : default operand/sum width of adder_behav
//   gp_t      : per-bit generate/propagate pair used inside a slice
//   num_slices: number of SLICE_W slices needed for a given width
package adder_behav_pkg;

  localparam int SLICE_W   = 4;
  localparam int WIDTH_DEF = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_behav_cla4.sv
// adder_behav_cla4 -- 4-bit carry-lookahead adder slice, purely combinational.
//   a, b : 4-bit operands
//   ci   : carry-in
//   s    : 4-bit sum
//   co   : carry-out
// Every internal carry is a flat sum-of-products of g/p/ci, so no carry
// ripples inside the slice; slices ripple among themselves at the top.
module adder_behav_cla4
  import adder_behav_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  gp_t  [SLICE_W-1:0] gp;
  logic [SLICE_W:0]   c;

  always_comb begin
    for (int i = 0; i < SLICE_W; i++) begin
      gp[i].g = a[i] & b[i];
      gp[i].p = a[i] ^ b[i];
    end
  end

  // Expanded lookahead equations.
  assign c[0] = ci;
  assign c[1] = gp[0].g
              | (gp[0].p & ci);
  assign c[2] = gp[1].g
              | (gp[1].p & gp[0].g)
              | (gp[1].p & gp[0].p & ci);
  assign c[3] = gp[2].g
              | (gp[2].p & gp[1].g)
              | (gp[2].p & gp[1].p & gp[0].g)
              | (gp[2].p & gp[1].p & gp[0].p & ci);
  assign c[4] = gp[3].g
              | (gp[3].p & gp[2].g)
              | (gp[3].p & gp[2].p & gp[1].g)
              | (gp[3].p & gp[2].p & gp[1].p & gp[0].g)
              | (gp[3].p & gp[2].p & gp[1].p & gp[0].p & ci);

  always_comb begin
    for (int i = 0; i < SLICE_W; i++) s[i] = gp[i].p ^ c[i];
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/adder_behav.sv
// adder_behav -- registered WIDTH-bit unsigned adder, {cout,sum} = a+b+cin.
//   a, b   : WIDTH-bit unsigned operands
//   cin    : carry-in
//   sum    : registered low WIDTH bits of the result (held when vld_i=0)
//   cout   : registered carry-out (held when vld_i=0)
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   vld_i  : operand valid
//   vld_o  : result valid, vld_i delayed by one cycle
//   ovf    : registered two's-complement overflow flag, present only when
//            ADDER_BEHAV_OVF_EN is defined
// WIDTH must be a multiple of SLICE_W (4..32). The datapath is a chain of
// 4-bit lookahead slices with ripple carry between them, then one register
// stage, giving exactly one cycle of latency.
module adder_behav
  import adder_behav_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  output logic             vld_o
`ifdef ADDER_BEHAV_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSL    = num_slices(WIDTH);
  localparam int STAGES = 1;

  logic [NSL:0]     carry;
  logic [WIDTH-1:0] s_comb;
  logic [STAGES:0]  vld_pipe;

  assign carry[0] = cin;

  for (genvar g = 0; g < NSL; g++) begin : g_slice
    adder_behav_cla4 u_cla4 (
      .a  (a[g*SLICE_W +: SLICE_W]),
      .b  (b[g*SLICE_W +: SLICE_W]),
      .ci (carry[g]),
      .s  (s_comb[g*SLICE_W +: SLICE_W]),
      .co (carry[g+1])
    );
  end

  // Valid tracks input every cycle, independent of the data hold.
  assign vld_pipe[0] = vld_i;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign vld_o = vld_pipe[STAGES];

  // Result registers load only on valid operands, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (vld_i) begin
      sum  <= s_comb;
      cout <= carry[NSL];
    end
  end

`ifdef ADDER_BEHAV_OVF_EN
  // Signed overflow: operands agree in sign but the sum's sign differs.
  logic ovf_comb;
  assign ovf_comb = (a[WIDTH-1] == b[WIDTH-1]) && (s_comb[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n)     ovf <= 1'b0;
    else if (vld_i) ovf <= ovf_comb;
  end
`endif

endmodule

// File: tb/tb_adder_behav.sv
// tb_adder_behav -- directed and random checks of adder_behav at WIDTH=4 and
// WIDTH=8 against an arithmetic reference model.
module tb_adder_behav;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, vld_i;
  logic [3:0] a, b, sum;
  logic       cin, cout, vld_o;
  logic [7:0] a8, b8, sum8;
  logic       cin8, cout8, vld_o8;
`ifdef ADDER_BEHAV_OVF_EN
  logic       ovf, ovf8;
`endif

  adder_behav #(.WIDTH(4)) dut4 (
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .vld_o(vld_o)
`ifdef ADDER_BEHAV_OVF_EN
    , .ovf(ovf)
`endif
  );

  adder_behav #(.WIDTH(8)) dut8 (
    .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8),
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .vld_o(vld_o8)
`ifdef ADDER_BEHAV_OVF_EN
    , .ovf(ovf8)
`endif
  );

  int ncmp  = 0;
  int nfail = 0;

  // Reference state: what each output should hold after the latest edge.
  logic [3:0] es;
  logic       ec, ev, eo;
  logic [7:0] es8;
  logic       ec8, ev8, eo8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Unsigned add at plain integer precision; overflow from the signed
  // interpretation falling outside the representable range.
  task automatic model(input int w, input int ta, input int tb, input int tc,
                       output int s, output logic c, output logic o);
    int t, sa, sb, st, lim;
    lim = 1 << w;
    t   = ta + tb + tc;
    s   = t % lim;
    c   = (t >= lim);
    sa  = (ta >= lim/2) ? ta - lim : ta;
    sb  = (tb >= lim/2) ? tb - lim : tb;
    st  = sa + sb + tc;
    o   = (st > lim/2 - 1) || (st < -(lim/2));
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic [7:0] ta8, input logic [7:0] tb8, input logic tc8);
    int s;
    rst_n = r; vld_i = v;
    a = ta; b = tb; cin = tc;
    a8 = ta8; b8 = tb8; cin8 = tc8;
    @(posedge clk);
    if (!r) begin
      es = '0; ec = 1'b0; ev = 1'b0; eo = 1'b0;
      es8 = '0; ec8 = 1'b0; ev8 = 1'b0; eo8 = 1'b0;
    end else begin
      ev = v; ev8 = v;
      if (v) begin
        model(4, int'(ta), int'(tb), int'(tc), s, ec, eo);
        es = 4'(s);
        model(8, int'(ta8), int'(tb8), int'(tc8), s, ec8, eo8);
        es8 = 8'(s);
      end
    end
    #1;
    chk("sum4",  32'(sum),  32'(es));
    chk("cout4", 32'(cout), 32'(ec));
    chk("vld4",  32'(vld_o), 32'(ev));
    chk("sum8",  32'(sum8), 32'(es8));
    chk("cout8", 32'(cout8), 32'(ec8));
    chk("vld8",  32'(vld_o8), 32'(ev8));
`ifdef ADDER_BEHAV_OVF_EN
    chk("ovf4",  32'(ovf),  32'(eo));
    chk("ovf8",  32'(ovf8), 32'(eo8));
`endif
  endtask

  initial begin
    // Reset state
    step(0, 1, 4'hF, 4'hF, 1, 8'hAA, 8'h55, 1);
    step(0, 0, 4'h0, 4'h0, 0, 8'h00, 8'h00, 0);
    // 0100+1100 -> 0000 c1 ; 8-bit all-ones wrap
    step(1, 1, 4'b0100, 4'b1100, 0, 8'hFF, 8'hFF, 1);
    chk("d_sum_0100_1100", 32'(sum), 32'h0);
    chk("d_sum8_ff",       32'(sum8), 32'hFF);
    // 1010+1100 -> 0110 c1 (signed overflow) ; 8-bit zero
    step(1, 1, 4'b1010, 4'b1100, 0, 8'h00, 8'h00, 0);
    chk("d_sum_1010_1100", 32'(sum), 32'h6);
    chk("d_sum8_zero",     32'(sum8), 32'h0);
    // Back-to-back
    step(1, 1, 4'b1111, 4'b1011, 1, 8'h80, 8'h80, 0);
    chk("b2b0", 32'({cout, sum}), 32'h1B);
    step(1, 1, 4'b1100, 4'b1101, 1, 8'h7F, 8'h01, 0);
    chk("b2b1", 32'({cout, sum}), 32'h1A);
    step(1, 1, 4'b0000, 4'b1011, 0, 8'h12, 8'h34, 1);
    chk("b2b2", 32'({cout, sum}), 32'h0B);
    // Hold when vld_i=0
    step(1, 1, 4'b0110, 4'b1010, 1, 8'hC3, 8'h3C, 1);
    step(1, 0, 4'b0011, 4'b0101, 0, 8'h01, 8'h02, 0);
    chk("hold_sum", 32'({cout, sum}), 32'h11);
    step(1, 0, 4'b1111, 4'b1111, 1, 8'hFF, 8'h01, 0);
    // 4-bit boundaries
    step(1, 1, 4'hF, 4'hF, 1, 8'h01, 8'hFF, 0);
    step(1, 1, 4'h0, 4'h0, 0, 8'hFF, 8'h00, 1);
    // Mid-operation reset with live operands, then first valid after it
    step(1, 1, 4'h9, 4'h9, 1, 8'h99, 8'h99, 1);
    step(0, 1, 4'h7, 4'h5, 1, 8'h77, 8'h55, 1);
    step(1, 0, 4'h3, 4'h3, 0, 8'h33, 8'h33, 0);
    step(1, 1, 4'h3, 4'h4, 1, 8'h33, 8'h44, 1);
    // Random traffic with sparse valids and occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/adder_behav.md
ADDER_BEHAV -- requirements
Module: adder_behav

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width; the SHALL-supported values are 4, 8, 12, …, 32 (multiples of 4).
REQ-002 Port clk  input  1  rising-edge clock; the block SHALL use only this clock.
REQ-003 Port rst_n  input  1  the block SHALL treat this as its reset: synchronous, active-low.
REQ-004 Port a  input  WIDTH  the block SHALL take this as the first unsigned operand.
REQ-005 Port b  input  WIDTH  the block SHALL take this as the second unsigned operand.
REQ-006 Port cin  input  1  the block SHALL take this as the carry-in.
REQ-007 Port sum  output  WIDTH  the block SHALL drive the registered low WIDTH bits of a+b+cin here.
REQ-008 Port cout  output  1  the block SHALL drive the registered carry-out (bit WIDTH of a+b+cin) here.
REQ-009 Port vld_i  input  1  the block SHALL treat this as the operand-valid qualifier.
REQ-010 Port vld_o  output  1  the block SHALL assert this when sum/cout hold a fresh result.
REQ-011 Port declaration order SHALL be a, b, cin, sum, cout, clk, rst_n, vld_i, vld_o, so that positional instantiations using the first five ports remain legal.

Function
REQ-012 On each rising clk edge with rst_n=1 and vld_i=1, {cout,sum} SHALL register a+b+cin computed at WIDTH+1 bits with no truncation before the carry.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled at edge N SHALL appear on sum/cout after edge N.
REQ-014 vld_o SHALL register vld_i each cycle (1-cycle delayed copy).
REQ-015 When vld_i=0, sum and cout SHALL hold their previous values; only vld_o updates.
REQ-016 Wrap-around: all-ones+all-ones+1 SHALL yield sum=all-ones, cout=1; zero+zero+0 SHALL yield sum=0, cout=0.
REQ-017 The adder datapath SHALL be purely combinational between the input pins and the output registers, with no internal pipeline stage.
REQ-018 Operands SHALL be treated as unsigned for sum/cout; no saturation.

Reset
REQ-019 While rst_n=0 at a rising clk edge, the block SHALL clear sum to 0, cout to 0 and vld_o to 0, regardless of vld_i.
REQ-020 If reset is asserted mid-operation, the block SHALL discard any in-flight result; the first valid result after reset deassertion SHALL appear one cycle after the first edge with rst_n=1 and vld_i=1.

Configuration
REQ-021 Macro ADDER_BEHAV_OVF_EN: when defined, the block SHALL add the port ovf  output  1, appended after vld_o and registered like sum, set to 1 when a and b, viewed as two's-complement, have equal sign bits and sum's sign bit differs from them.
REQ-022 Without ADDER_BEHAV_OVF_EN, the ovf port and its logic SHALL be absent, with all other behaviour identical.
REQ-023 ovf SHALL reset to 0 and hold when vld_i=0.

Structure
REQ-024 Shared package adder_behav_pkg SHALL hold the constant SLICE_W=4 and the default WIDTH constant.
REQ-025 Sub-module adder_behav_cla4 SHALL implement a 4-bit carry-lookahead slice (generate/propagate, inputs a,b,ci; outputs s,co).
REQ-026 The top level SHALL chain WIDTH/SLICE_W slices through a generate loop, ripple-carry between slices, followed by the output registers.

Verification
REQ-027 WIDTH=4, vld_i=1, a=0100, b=1100, cin=0 -> after 1 edge, sum=0000, cout=1, vld_o=1; with OVF_EN, ovf=0.
REQ-028 a=1010, b=1100, cin=0 -> sum=0110, cout=1; with OVF_EN, ovf=1.
REQ-029 Back-to-back operands (1111,1011,1), (1100,1101,1), (0000,1011,0) on consecutive cycles -> consecutive results (1011,1), (1010,1), (1011,0).
REQ-030 Apply a=0110, b=1010, cin=1 with vld_i=1, then change operands with vld_i=0 -> sum holds 0001, cout holds 1, vld_o=0.
REQ-031 Assert rst_n=0 for 1 edge with vld_i=1 and nonzero operands -> sum=0, cout=0, vld_o=0 after that edge.
REQ-032 WIDTH=8: 8'hFF+8'hFF+1 -> sum=8'hFF, cout=1; 8'h00+8'h00+0 -> sum=0, cout=0.
